// File: rtl/pad_overlay_vga.sv
// pad_overlay_vga
//   VGA timing generator and pixel merger for NUM_PADS rectangular pad regions.
//   Produces the background ROM address, overlays pad hit highlights (held for
//   HOLD_FRAMES frames) and runs a frame-synchronous SPLASH/PLAY/PAUSE screen
//   state machine driven by edge-detected controller buttons.
//
// Ports
//   iVGA_CLK      pixel clock, all logic on rising edge
//   iRST          synchronous active-high reset
//   iSENSOR       per-pad 6-bit hit fields (asynchronous), pad i at [6i+5:6i]
//   iCTRL         controller buttons (asynchronous, active-high)
//   iBG_BGR       background {B,G,R}, valid BG_LAT cycles after oADDR
//   oADDR         background address y*H_ACTIVE+x
//   oHS / oVS     active-low syncs
//   oBLANK_n      high during active video
//   oB / oG / oR  pixel colour
//   oSCREEN       committed screen (0 SPLASH, 1 PLAY, 2 PAUSE)
//   oHIT_PULSE    one-cycle pulse per new pad hit while in PLAY
//   oFRAME_START  one-cycle pulse at hcnt=0, vcnt=0
//
// Screen FSM
//   state    | meaning
//   S_SPLASH | title screen, white banner over background, no highlights
//   S_PLAY   | background with pad hit highlights
//   S_PAUSE  | background dimmed to half intensity, no highlights
module pad_overlay_vga #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_PADS    = 3,
    parameter logic [10*NUM_PADS-1:0] PAD_X0 = {10'd489, 10'd336, 10'd193},
    parameter logic [10*NUM_PADS-1:0] PAD_X1 = {10'd447, 10'd296, 10'd154},
    parameter logic [10*NUM_PADS-1:0] PAD_Y0 = {10'd260, 10'd260, 10'd260},
    parameter logic [10*NUM_PADS-1:0] PAD_Y1 = {10'd180, 10'd180, 10'd180},
    parameter int HOLD_FRAMES = 4,
    parameter int BG_LAT      = 2,
    parameter int BAN_X0      = 75,
    parameter int BAN_X1      = 572,
    parameter int BAN_Y0      = 60,
    parameter int BAN_Y1      = 98
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST,
    input  logic [6*NUM_PADS-1:0] iSENSOR,
    input  logic [3:0]            iCTRL,
    input  logic [23:0]           iBG_BGR,
    output logic [18:0]           oADDR,
    output logic                  oHS,
    output logic                  oVS,
    output logic                  oBLANK_n,
    output logic [7:0]            oB,
    output logic [7:0]            oG,
    output logic [7:0]            oR,
    output logic [1:0]            oSCREEN,
    output logic [NUM_PADS-1:0]   oHIT_PULSE,
    output logic                  oFRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int NPIX    = H_ACTIVE * V_ACTIVE;

    localparam logic [23:0] COL_LIGHT = 24'h90EE90;
    localparam logic [23:0] COL_MID   = 24'h32CD32;
    localparam logic [23:0] COL_DARK  = 24'h006400;
    localparam logic [23:0] COL_WHITE = 24'hFFFFFF;

    typedef enum logic [1:0] {
        S_SPLASH = 2'd0,
        S_PLAY   = 2'd1,
        S_PAUSE  = 2'd2
    } screen_t;

    function automatic logic [1:0] pad_level(input logic [5:0] f);
        if (f[1:0] != 2'b00)      return 2'd1;
        else if (f[3:2] != 2'b00) return 2'd2;
        else if (f[5:4] != 2'b00) return 2'd3;
        else                      return 2'd0;
    endfunction

    function automatic logic [23:0] level_colour(input logic [1:0] l);
        case (l)
            2'd1:    return COL_LIGHT;
            2'd2:    return COL_MID;
            2'd3:    return COL_DARK;
            default: return 24'h000000;
        endcase
    endfunction

    // Bounds may be given in either order; both are exclusive.
    function automatic logic between(input logic [9:0] v, input logic [9:0] a,
                                     input logic [9:0] b);
        return ((v > a) && (v < b)) || ((v > b) && (v < a));
    endfunction

    // ---------------- timing ----------------
    logic [9:0]  hcnt_q, vcnt_q;
    logic [18:0] addr_q, addr_d;
    logic        active, hs_on, vs_on, frame_start, frame_end;

    assign active      = (hcnt_q < 10'(H_ACTIVE)) && (vcnt_q < 10'(V_ACTIVE));
    assign hs_on       = (hcnt_q >= 10'(H_ACTIVE + H_FP)) &&
                         (hcnt_q <  10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on       = (vcnt_q >= 10'(V_ACTIVE + V_FP)) &&
                         (vcnt_q <  10'(V_ACTIVE + V_FP + V_SYNC));
    assign frame_end   = (hcnt_q == 10'(H_TOTAL - 1)) && (vcnt_q == 10'(V_TOTAL - 1));
    // Gated by iRST so no frame start is reported while reset is held.
    assign frame_start = (hcnt_q == 10'd0) && (vcnt_q == 10'd0) && !iRST;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (hcnt_q == 10'(H_TOTAL - 1)) begin
            hcnt_q <= '0;
            vcnt_q <= (vcnt_q == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt_q + 10'd1;
        end else begin
            hcnt_q <= hcnt_q + 10'd1;
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (frame_end)
            addr_d = '0;
        else if (active)
            addr_d = (addr_q == 19'(NPIX - 1)) ? 19'd0 : addr_q + 19'd1;
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) addr_q <= '0;
        else      addr_q <= addr_d;
    end

    // ---------------- synchronisers ----------------
    logic [6*NUM_PADS-1:0] sens_m_q, sens_s_q, sens_p_q;
    logic [3:0]            ctrl_m_q, ctrl_s_q, ctrl_p_q, ctrl_rise;
    logic                  ctrl0_unused;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            sens_m_q <= '0;
            sens_s_q <= '0;
            sens_p_q <= '0;
            ctrl_m_q <= '0;
            ctrl_s_q <= '0;
            ctrl_p_q <= '0;
        end else begin
            sens_m_q <= iSENSOR;
            sens_s_q <= sens_m_q;
            sens_p_q <= sens_s_q;
            ctrl_m_q <= iCTRL;
            ctrl_s_q <= ctrl_m_q;
            ctrl_p_q <= ctrl_s_q;
        end
    end

    assign ctrl_rise    = ctrl_s_q & ~ctrl_p_q;
    assign ctrl0_unused = ctrl_rise[0];

    // ---------------- screen FSM ----------------
    screen_t state_q, state_d, pend_q, pend_d, req;
    logic    pend_vld_q, pend_vld_d, req_vld;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state_q    <= S_SPLASH;
            pend_q     <= S_SPLASH;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        req        = state_q;
        req_vld    = 1'b0;
        if (ctrl_rise[3]) begin
            req     = S_SPLASH;
            req_vld = 1'b1;
        end else begin
            case (state_q)
                S_SPLASH: if (ctrl_rise[1]) begin req = S_PLAY;  req_vld = 1'b1; end
                S_PLAY:   if (ctrl_rise[2]) begin req = S_PAUSE; req_vld = 1'b1; end
                S_PAUSE:  if (ctrl_rise[2]) begin req = S_PLAY;  req_vld = 1'b1; end
                default:  ;
            endcase
        end
        if (req_vld) begin
            pend_d     = req;
            pend_vld_d = 1'b1;
        end
        // Commit only on a frame boundary to avoid mid-frame tearing.
        if (frame_start) begin
            if (pend_vld_d) state_d = pend_d;
            pend_vld_d = 1'b0;
        end
    end

    // ---------------- pad hold ----------------
    logic [1:0]          lvl_q  [NUM_PADS];
    logic [3:0]          hold_q [NUM_PADS];
    logic [NUM_PADS-1:0] pad_on, hit;

    always_ff @(posedge iVGA_CLK) begin
        for (int i = 0; i < NUM_PADS; i++) begin
            if (iRST) begin
                lvl_q[i]  <= '0;
                hold_q[i] <= '0;
            end else if (sens_s_q[6*i +: 6] != 6'd0) begin
                lvl_q[i]  <= pad_level(sens_s_q[6*i +: 6]);
                hold_q[i] <= 4'(HOLD_FRAMES);
            end else if (frame_start && (hold_q[i] != 4'd0)) begin
                hold_q[i] <= hold_q[i] - 4'd1;
            end
        end
    end

    always_comb begin
        pad_on = '0;
        hit    = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            pad_on[i] = (hold_q[i] != 4'd0);
            hit[i]    = (sens_s_q[6*i +: 6] != 6'd0) && (sens_p_q[6*i +: 6] == 6'd0) &&
                        (state_q == S_PLAY);
        end
    end

    // ---------------- pixel pipeline ----------------
    // BG_LAT stages here plus the output register give BG_LAT+1 total latency.
    logic [9:0] x_pipe_q [BG_LAT];
    logic [9:0] y_pipe_q [BG_LAT];
    logic       act_pipe_q [BG_LAT];
    logic       hs_pipe_q  [BG_LAT];
    logic       vs_pipe_q  [BG_LAT];

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < BG_LAT; i++) begin
                x_pipe_q[i]   <= '0;
                y_pipe_q[i]   <= '0;
                act_pipe_q[i] <= 1'b0;
                hs_pipe_q[i]  <= 1'b0;
                vs_pipe_q[i]  <= 1'b0;
            end
        end else begin
            x_pipe_q[0]   <= hcnt_q;
            y_pipe_q[0]   <= vcnt_q;
            act_pipe_q[0] <= active;
            hs_pipe_q[0]  <= hs_on;
            vs_pipe_q[0]  <= vs_on;
            for (int i = 1; i < BG_LAT; i++) begin
                x_pipe_q[i]   <= x_pipe_q[i-1];
                y_pipe_q[i]   <= y_pipe_q[i-1];
                act_pipe_q[i] <= act_pipe_q[i-1];
                hs_pipe_q[i]  <= hs_pipe_q[i-1];
                vs_pipe_q[i]  <= vs_pipe_q[i-1];
            end
        end
    end

    logic [9:0]  px_x, px_y;
    logic        px_act, pad_sel, in_banner;
    logic [23:0] pad_col, pix_d;

    assign px_x      = x_pipe_q[BG_LAT-1];
    assign px_y      = y_pipe_q[BG_LAT-1];
    assign px_act    = act_pipe_q[BG_LAT-1];
    assign in_banner = (px_x > 10'(BAN_X0)) && (px_x < 10'(BAN_X1)) &&
                       (px_y > 10'(BAN_Y0)) && (px_y < 10'(BAN_Y1));

    always_comb begin
        pad_sel = 1'b0;
        pad_col = 24'h000000;
        // Walk downwards so the lowest-index matching pad is assigned last.
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (pad_on[i] && between(px_x, PAD_X0[10*i +: 10], PAD_X1[10*i +: 10]) &&
                between(px_y, PAD_Y0[10*i +: 10], PAD_Y1[10*i +: 10])) begin
                pad_sel = 1'b1;
                pad_col = level_colour(lvl_q[i]);
            end
        end
        pix_d = iBG_BGR;
        case (state_q)
            S_PLAY:   if (pad_sel) pix_d = pad_col;
            S_SPLASH: if (in_banner) pix_d = COL_WHITE;
            S_PAUSE:  pix_d = {1'b0, iBG_BGR[23:17], 1'b0, iBG_BGR[15:9], 1'b0, iBG_BGR[7:1]};
            default:  ;
        endcase
        if (!px_act) pix_d = 24'h000000;
    end

    logic [23:0] rgb_q;
    logic        hs_n_q, vs_n_q, blank_n_q;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            rgb_q     <= '0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= pix_d;
            hs_n_q    <= ~hs_pipe_q[BG_LAT-1];
            vs_n_q    <= ~vs_pipe_q[BG_LAT-1];
            blank_n_q <= px_act;
        end
    end

    assign oADDR        = addr_q;
    assign oB           = rgb_q[23:16];
    assign oG           = rgb_q[15:8];
    assign oR           = rgb_q[7:0];
    assign oHS          = hs_n_q;
    assign oVS          = vs_n_q;
    assign oBLANK_n     = blank_n_q;
    assign oSCREEN      = state_q;
    assign oHIT_PULSE   = hit;
    assign oFRAME_START = frame_start;

endmodule

// File: tb/tb_pad_overlay_vga.sv
// Directed bench for pad_overlay_vga using a reduced 24x15 raster
// (16x10 active) so that many frames fit in a short run.
module tb_pad_overlay_vga;

    localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
    localparam int V_ACT = 10, V_FP = 1, V_SY = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int NP    = 3;

    logic          clk = 1'b0;
    logic          iRST;
    logic [17:0]   iSENSOR;
    logic [3:0]    iCTRL;
    logic [23:0]   iBG_BGR;
    logic [18:0]   oADDR;
    logic          oHS, oVS, oBLANK_n, oFRAME_START;
    logic [7:0]    oB, oG, oR;
    logic [1:0]    oSCREEN;
    logic [NP-1:0] oHIT_PULSE;

    logic [18:0] addr_d1 = '0, addr_d2 = '0;
    logic        bg_force = 1'b0;
    int          hit_cnt [NP] = '{0, 0, 0};
    int          n_cmp = 0, n_bad = 0;

    pad_overlay_vga #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .NUM_PADS(NP),
        .PAD_X0({10'd10, 10'd10, 10'd1}), .PAD_X1({10'd15, 10'd4, 10'd6}),
        .PAD_Y0({10'd5, 10'd1, 10'd1}),   .PAD_Y1({10'd9, 10'd5, 10'd5}),
        .HOLD_FRAMES(4), .BG_LAT(2),
        .BAN_X0(1), .BAN_X1(14), .BAN_Y0(6), .BAN_Y1(9)
    ) dut (
        .iVGA_CLK(clk), .iRST(iRST), .iSENSOR(iSENSOR), .iCTRL(iCTRL),
        .iBG_BGR(iBG_BGR), .oADDR(oADDR), .oHS(oHS), .oVS(oVS),
        .oBLANK_n(oBLANK_n), .oB(oB), .oG(oG), .oR(oR), .oSCREEN(oSCREEN),
        .oHIT_PULSE(oHIT_PULSE), .oFRAME_START(oFRAME_START)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bgf(input logic [18:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo ^ 8'hA5, lo + 8'd3, 8'h11};
    endfunction

    // Background ROM model: two-cycle latency from oADDR.
    always @(posedge clk) begin
        addr_d1 <= oADDR;
        addr_d2 <= addr_d1;
    end
    assign iBG_BGR = bg_force ? 24'hFF8040 : bgf(addr_d2);

    always @(negedge clk)
        for (int i = 0; i < NP; i++)
            if (oHIT_PULSE[i]) hit_cnt[i] <= hit_cnt[i] + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (oFRAME_START === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("fs_timeout", 32'd0, 32'd1);
    endtask

    // Returns the pin colour of pixel (x,y) in the frame after the next frame start.
    task automatic sample_px(input int x, input int y, output logic [23:0] col);
        wait_fs();
        repeat (y * H_TOT + x + 3) @(negedge clk);
        check("px_blank", 32'(oBLANK_n), 32'd1);
        col = {oB, oG, oR};
    endtask

    task automatic chk_rst();
        check("rst_hs",    32'(oHS), 32'd1);
        check("rst_vs",    32'(oVS), 32'd1);
        check("rst_blank", 32'(oBLANK_n), 32'd0);
        check("rst_rgb",   32'({oB, oG, oR}), 32'd0);
        check("rst_scr",   32'(oSCREEN), 32'd0);
        check("rst_hit",   32'(oHIT_PULSE), 32'd0);
        check("rst_fs",    32'(oFRAME_START), 32'd0);
        check("rst_addr",  32'(oADDR), 32'd0);
    endtask

    task automatic pulse_ctrl(input logic [3:0] v);
        iCTRL = v;
        repeat (3) @(negedge clk);
        iCTRL = 4'd0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int          kk, h, v, ea, e_tim, e_addr, nhs, nvs, nbl, nfs;
        logic        eb, ehs, evs;
        logic [23:0] ec, col;

        iRST = 1'b1; iSENSOR = '0; iCTRL = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_rst();
        @(posedge clk); #1 iRST = 1'b0;
        @(negedge clk);
        check("fs_after_rst", 32'(oFRAME_START), 32'd1);

        // One full frame: sync/blank placement, address sequence, colour latency.
        wait_fs();
        e_tim = 0; e_addr = 0; nhs = 0; nvs = 0; nbl = 0; nfs = 0;
        for (int k = 0; k < FRAME; k++) begin
            kk  = (k + FRAME - 3) % FRAME;
            h   = kk % H_TOT;
            v   = kk / H_TOT;
            eb  = (h < H_ACT) && (v < V_ACT);
            ehs = !((h >= 18) && (h < 21));
            evs = !((v >= 11) && (v < 13));
            if (!eb) ec = 24'h0;
            else if (h > 1 && h < 14 && v > 6 && v < 9) ec = 24'hFFFFFF;
            else ec = bgf(19'(v * H_ACT + h));
            if ({oHS, oVS, oBLANK_n} !== {ehs, evs, eb} || {oB, oG, oR} !== ec) e_tim++;
            if (oFRAME_START !== (k == 0)) e_tim++;
            if (!oHS) nhs++;
            if (!oVS) nvs++;
            if (oBLANK_n) nbl++;
            if (oFRAME_START) nfs++;
            h = k % H_TOT;
            v = k / H_TOT;
            if (h < H_ACT && v < V_ACT) ea = v * H_ACT + h;
            else if (v < V_ACT - 1)     ea = (v + 1) * H_ACT;
            else                        ea = 0;
            if (oADDR !== 19'(ea)) e_addr++;
            @(negedge clk);
        end
        check("hs_low_cycles", 32'(nhs), 32'(H_SY * V_TOT));
        check("vs_low_cycles", 32'(nvs), 32'(V_SY * H_TOT));
        check("blank_hi",      32'(nbl), 32'(H_ACT * V_ACT));
        check("fs_count",      32'(nfs), 32'd1);
        check("pin_timing",    32'(e_tim), 32'd0);
        check("addr_seq",      32'(e_addr), 32'd0);

        // SPLASH -> PLAY, committed only at the next frame start.
        repeat (100) @(negedge clk);
        pulse_ctrl(4'b0010);
        check("scr_midframe", 32'(oSCREEN), 32'd0);
        wait_fs();
        check("scr_at_fs", 32'(oSCREEN), 32'd0);
        @(negedge clk);
        check("scr_play", 32'(oSCREEN), 32'd1);

        // Pad priority: pad0 MID over DARK, pad1 LIGHT, pad0 wins overlap.
        iSENSOR = {6'b000000, 6'b000001, 6'b110100};
        repeat (6) @(negedge clk);
        check("hit0_once", 32'(hit_cnt[0]), 32'd1);
        check("hit1_once", 32'(hit_cnt[1]), 32'd1);
        check("hit2_none", 32'(hit_cnt[2]), 32'd0);
        sample_px(3, 3, col);  check("pad0_mid",   32'(col), 32'h32CD32);
        sample_px(7, 3, col);  check("pad1_light", 32'(col), 32'h90EE90);
        sample_px(5, 3, col);  check("overlap",    32'(col), 32'h32CD32);
        sample_px(0, 0, col);  check("bg_00",      32'(col), 32'(bgf(19'd0)));
        sample_px(12, 3, col); check("bg_pad2off", 32'(col), 32'(bgf(19'd60)));
        iSENSOR = '0;

        // Hold: pad2 set for one frame, then highlight persists through the hold count.
        wait_fs();
        iSENSOR = {6'b010000, 12'd0};
        sample_px(12, 7, col); check("hold_set", 32'(col), 32'h006400);
        iSENSOR = '0;
        check("hit2_once", 32'(hit_cnt[2]), 32'd1);
        sample_px(12, 7, col); check("hold_3", 32'(col), 32'h006400);
        sample_px(12, 7, col); check("hold_2", 32'(col), 32'h006400);
        sample_px(12, 7, col); check("hold_1", 32'(col), 32'h006400);
        sample_px(12, 7, col); check("hold_end", 32'(col), 32'(bgf(19'd124)));

        // PLAY -> PAUSE: dimmed background, no hit pulses, no highlights.
        pulse_ctrl(4'b0100);
        wait_fs();
        @(negedge clk);
        check("scr_pause", 32'(oSCREEN), 32'd2);
        bg_force = 1'b1;
        iSENSOR  = {12'd0, 6'b000011};
        repeat (6) @(negedge clk);
        check("hit_pause", 32'(hit_cnt[0]), 32'd1);
        sample_px(3, 3, col); check("pause_dim", 32'(col), 32'h7F4020);

        // ctrl[3] beats simultaneous ctrl[2].
        pulse_ctrl(4'b1100);
        wait_fs();
        @(negedge clk);
        check("scr_prio", 32'(oSCREEN), 32'd0);
        bg_force = 1'b0;
        iSENSOR  = '0;
        sample_px(3, 3, col); check("splash_nopad", 32'(col), 32'(bgf(19'd51)));
        sample_px(5, 7, col); check("banner",       32'(col), 32'hFFFFFF);

        // Mid-frame reset discards a pending change and restarts timing.
        pulse_ctrl(4'b0010);
        wait_fs();
        @(negedge clk);
        check("scr_play2", 32'(oSCREEN), 32'd1);
        pulse_ctrl(4'b0100);
        repeat (5 * H_TOT) @(negedge clk);
        iRST = 1'b1;
        @(negedge clk);
        chk_rst();
        @(posedge clk); #1 iRST = 1'b0;
        @(negedge clk);
        check("fs_restart", 32'(oFRAME_START), 32'd1);
        check("scr_reset",  32'(oSCREEN), 32'd0);
        repeat (5) @(negedge clk);
        check("addr_restart", 32'(oADDR), 32'd5);
        check("fs_single",    32'(oFRAME_START), 32'd0);
        wait_fs();
        @(negedge clk);
        check("pend_drop", 32'(oSCREEN), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pad_overlay_vga.md
Name: pad_overlay_vga

Overview:
Parametrised successor to the single-resolution pad display controller. It generates VGA timing from parameters, supplies the background ROM address and merges background pixels with per-pad hit highlights for NUM_PADS rectangular pads. Highlights hold for a programmable number of frames. A frame-synchronous screen state machine (SPLASH/PLAY/PAUSE) is driven by edge-detected controller buttons. It sits between the background/palette ROMs and the board VGA DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
NUM_PADS, 3, number of pad regions (1..8)
PAD_X0 / PAD_X1, packed 10b per pad, {489,336,193} / {447,296,154} style, exclusive x bounds, pad i in bits [10i+9:10i]
PAD_Y0 / PAD_Y1, packed 10b per pad, exclusive y bounds
HOLD_FRAMES, 4, frames a highlight persists after the sensor clears (1..15)
BG_LAT, 2, cycles from oADDR to valid iBG_BGR

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST  in  1  reset, synchronous, active-high
iSENSOR  in  6*NUM_PADS  per-pad hit field, asynchronous; pad i = bits [6i+5:6i]
iCTRL  in  4  controller buttons, asynchronous, active-high
iBG_BGR  in  24  background {B,G,R} from palette, valid BG_LAT cycles after oADDR
oADDR  out  19  background pixel address, y*H_ACTIVE+x, active region only
oHS / oVS  out  1  sync, active-low
oBLANK_n  out  1  high during active video
oB / oG / oR  out  8 each  pixel colour
oSCREEN  out  2  current screen: 0 SPLASH, 1 PLAY, 2 PAUSE
oHIT_PULSE  out  NUM_PADS  one-cycle pulse per new pad hit
oFRAME_START  out  1  one-cycle pulse at first cycle of a frame (hcnt=0, vcnt=0)

Behaviour:
- Timing: hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, where H_TOTAL and V_TOTAL are the sums of their respective parameters. Active region is hcnt<H_ACTIVE and vcnt<V_ACTIVE. HS is low for hcnt in [H_ACTIVE+H_FP, +H_SYNC). VS uses the same rule on vcnt.
- Address: an incrementing counter (no divide/modulo) reset to 0 at frame start. Advances only on active pixels, so it wraps to 0 after H_ACTIVE*V_ACTIVE-1.
- Pipeline: x/y, active flag and sync are delayed BG_LAT+1 stages. oB/oG/oR/oHS/oVS/oBLANK_n are registered and mutually aligned, with total latency BG_LAT+1 from counter to pin. oB/oG/oR are 0 whenever blanked.
- Sensor path: 2-flop synchroniser on iSENSOR and iCTRL.
- Pad level from the 6-bit field, highest priority first: bits[1:0] nonzero -> LIGHT 0x90EE90; bits[3:2] -> MID 0x32CD32; bits[5:4] -> DARK 0x006400; all zero -> none.
- Hold: each pad has a latched level and a 4b hold counter. While the synchronised field is nonzero, the level is updated every cycle and the counter is loaded with HOLD_FRAMES. At oFRAME_START the counter decrements if nonzero and the field is zero. The highlight is shown while the counter is nonzero.
- oHIT_PULSE[i]: pad field goes from zero to nonzero, only while screen=PLAY.
- Pixel merge, PLAY: the lowest-index pad whose rectangle strictly contains (x,y) and whose highlight is active supplies the colour; otherwise iBG_BGR.
- Pixel merge, SPLASH: white 0xFFFFFF banner for x in (75,572), y in (60,98); otherwise iBG_BGR with no pad highlights.
- Pixel merge, PAUSE: iBG_BGR with each channel shifted right 1; no pad highlights.
- Screen FSM, button rising edges (post-sync): ctrl[3] takes priority over all others and goes to SPLASH from any state. SPLASH: ctrl[1] -> PLAY. PLAY: ctrl[2] -> PAUSE. PAUSE: ctrl[2] -> PLAY.
- An edge only sets a pending next-state register; a later edge overwrites it. The state changes at the next oFRAME_START, so there is no mid-frame tearing. oSCREEN reflects the committed state.
- Simultaneous edges resolve by the same priority. A pending change is discarded on reset.
- Reset (sync, iRST=1): counters, address, pipeline and hold counters = 0; state SPLASH; no pending change. oHS=oVS=1, oBLANK_n=0, colour 0, oHIT_PULSE=0, oFRAME_START=0.
- Reset asserted mid-frame restarts timing at hcnt=vcnt=0 on the cycle after release.

Test Plan:
- Timing: defaults, reset 5 cycles -> HS low exactly 96 cycles per 800-cycle line; VS low 2 lines per 525; 307200 oBLANK_n-high cycles per frame; oADDR 0..307199 then 0.
- Latency: iBG_BGR driven as a function of the BG_LAT-delayed oADDR -> colour at pin matches address-derived value for (x,y) with BG_LAT+1 alignment to oBLANK_n.
- Pad priority: PLAY, iSENSOR pad0 = 6'b110100 -> pixel (170,220) = 0x32CD32 (MID wins over DARK); pad1 = 6'b000001 -> pixel (310,210) = 0x90EE90; pixel (100,100) = background.
- Hold: pad2 field nonzero for 1 frame, then 0 -> highlight visible for exactly HOLD_FRAMES=4 further frame starts, then background; oHIT_PULSE[2] high exactly 1 cycle.
- FSM: SPLASH, pulse ctrl[1] mid-frame -> oSCREEN stays 0 until next oFRAME_START, then 1. ctrl[2] and ctrl[3] in the same cycle -> SPLASH. In PAUSE, background 0xFF8040 -> output 0x7F4020.
- Reset mid-frame: assert iRST at line 200 -> all outputs at reset values next cycle, oSCREEN=0; after release first oFRAME_START occurs 1 cycle later.
